// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, slave-select field position and arbiter state encoding
package bus_pkg;
  localparam int ADDR_W = 32;
  localparam int NUM_MASTERS = 2;
  localparam int NUM_SLAVES = 4;
  localparam int SS_HI = 31;
  localparam int SS_LO = 30;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: master request/grant and slave bus signals of the two-master arbiter
//   arb    : arbiter side (takes requests and slave_ready, drives grant/done/bus)
//   master : requesting masters (drive req/addr/rw, see grant/done)
//   slave  : slaves (drive slave_ready, see bus_addr/bus_rw/bus_valid)
interface bus_arbiter_if;
  import bus_pkg::*;
  logic [NUM_MASTERS-1:0] m_req, m_rw, m_grant, m_done;
  logic [ADDR_W-1:0] m_addr0, m_addr1, bus_addr;
  logic [NUM_SLAVES-1:0] slave_ready;
  logic bus_rw, bus_valid, timeout_err;
  modport arb(input m_req, m_addr0, m_addr1, m_rw, slave_ready,
              output m_grant, m_done, bus_addr, bus_rw, bus_valid, timeout_err);
  modport master(output m_req, m_addr0, m_addr1, m_rw, input m_grant, m_done);
  modport slave(output slave_ready, input bus_addr, bus_rw, bus_valid);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: two-master round-robin choice
//   req  : request levels, bit i = master i
//   last : index of the master granted last
//   pick : one-hot winner, zero when nobody requests
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  assign pick = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master bus arbiter with per-transaction timeout
//   clk, reset : clock, asynchronous active-high reset
//   bus        : arb modport carrying requests, grants, completion and slave bus
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic       clk,
  input logic       reset,
  bus_arbiter_if.arb bus
);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);
  state_t state_q;
  logic [NUM_MASTERS-1:0] grant_q, done_q, pick;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic rw_q, valid_q, terr_q, last_q, sel_ready, hit_to;
  rr_pick u_pick (.req(bus.m_req), .last(last_q), .pick(pick));
  // only the slave addressed by the latched transaction may complete it
  assign sel_ready = bus.slave_ready[addr_q[SS_HI:SS_LO]];
  assign hit_to = state_q == WAIT && cnt_q == TO;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else
      case (state_q)
        IDLE:
          if (|bus.m_req) begin
            grant_q <= pick;
            addr_q  <= pick[1] ? bus.m_addr1 : bus.m_addr0;
            rw_q    <= pick[1] ? bus.m_rw[1] : bus.m_rw[0];
            valid_q <= 1'b1;
            cnt_q   <= 8'd1;
            state_q <= ADDR;
          end
        ADDR, WAIT:
          // ready is checked first so a same-cycle ready beats the timeout
          if (sel_ready || hit_to) begin
            valid_q <= 1'b0;
            done_q  <= grant_q;
            terr_q  <= !sel_ready;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= WAIT;
          end
        DONE: begin
          done_q  <= '0;
          terr_q  <= 1'b0;
          last_q  <= grant_q[1];
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
  assign bus.m_grant     = grant_q;
  assign bus.m_done      = done_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_valid   = valid_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of grant order, latency, timeout, slave select and reset
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errs = 0;
  int nv;
  bus_arbiter_if bus ();
  bus_arbiter #(.TIMEOUT_CYCLES(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_outs(input string tag);
    check({tag, "_grant"}, 32'(bus.m_grant), 32'h0);
    check({tag, "_done"}, 32'(bus.m_done), 32'h0);
    check({tag, "_valid"}, 32'(bus.bus_valid), 32'h0);
    check({tag, "_terr"}, 32'(bus.timeout_err), 32'h0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    bus.m_req = '0;
    bus.m_addr0 = '0;
    bus.m_addr1 = '0;
    bus.m_rw = '0;
    bus.slave_ready = '0;
    @(negedge clk);
    idle_outs("rst");
    check("rst_addr", bus.bus_addr, 32'h0);
    check("rst_rw", 32'(bus.bus_rw), 32'h0);
    reset = 1'b0;
    // single write from master 0 with immediate ready
    bus.m_req = 2'b01;
    bus.m_addr0 = 32'h4000_0010;
    bus.m_rw = 2'b01;
    @(negedge clk);
    check("single_grant", 32'(bus.m_grant), 32'h1);
    check("single_addr", bus.bus_addr, 32'h4000_0010);
    check("single_rw", 32'(bus.bus_rw), 32'h1);
    check("single_valid", 32'(bus.bus_valid), 32'h1);
    check("single_nodone", 32'(bus.m_done), 32'h0);
    bus.m_req = 2'b00;
    bus.slave_ready = 4'b0010;
    @(negedge clk);
    check("single_done", 32'(bus.m_done), 32'h1);
    check("single_validlo", 32'(bus.bus_valid), 32'h0);
    check("single_grant_done", 32'(bus.m_grant), 32'h1);
    check("single_terr", 32'(bus.timeout_err), 32'h0);
    bus.slave_ready = 4'b0000;
    @(negedge clk);
    idle_outs("single_idle");
    check("single_addr_hold", bus.bus_addr, 32'h4000_0010);
    // contention from reset: strict alternation starting at master 0
    pulse_reset();
    bus.m_addr0 = 32'h0000_0100;
    bus.m_addr1 = 32'h4000_0200;
    bus.m_rw = 2'b01;
    bus.slave_ready = 4'b1111;
    bus.m_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_grant", 32'(bus.m_grant), 32'(exp_g[i]));
      check("rr_rw", 32'(bus.bus_rw), exp_g[i] == 2'b01 ? 32'h1 : 32'h0);
      @(negedge clk);
      check("rr_done", 32'(bus.m_done), 32'(exp_g[i]));
      if (i == 3) bus.m_req = 2'b00;
      @(negedge clk);
    end
    check("rr_idle", 32'(bus.m_grant), 32'h0);
    // timeout on slave 3 while every other slave signals ready
    bus.m_addr1 = 32'hC000_0000;
    bus.slave_ready = 4'b0111;
    bus.m_req = 2'b10;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.m_req = 2'b00;
      if (!bus.bus_valid) break;
      nv++;
    end
    check("to_valid_cycles", 32'(nv), 32'd15);
    check("to_done", 32'(bus.m_done), 32'h2);
    check("to_terr", 32'(bus.timeout_err), 32'h1);
    @(negedge clk);
    idle_outs("to_after");
    // ready arriving on the very cycle the timeout expires wins
    bus.slave_ready = 4'b0000;
    bus.m_req = 2'b10;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.m_req = 2'b00;
      if (k == 15) bus.slave_ready = 4'b1000;
    end
    @(negedge clk);
    check("tie_done", 32'(bus.m_done), 32'h2);
    check("tie_terr", 32'(bus.timeout_err), 32'h0);
    bus.slave_ready = 4'b0000;
    @(negedge clk);
    // wrong-slave ready ignored, request/address changes do not disturb the transfer
    bus.m_addr0 = 32'h8000_0000;
    bus.m_rw = 2'b00;
    bus.m_req = 2'b01;
    @(negedge clk);
    check("ws_addr", bus.bus_addr, 32'h8000_0000);
    bus.slave_ready = 4'b0001;
    bus.m_addr0 = 32'h0000_1234;
    bus.m_req = 2'b00;
    @(negedge clk);
    check("ws_valid", 32'(bus.bus_valid), 32'h1);
    check("ws_nodone", 32'(bus.m_done), 32'h0);
    check("ws_addr_hold", bus.bus_addr, 32'h8000_0000);
    bus.slave_ready = 4'b1011;
    @(negedge clk);
    check("ws_still_valid", 32'(bus.bus_valid), 32'h1);
    bus.slave_ready = 4'b0100;
    @(negedge clk);
    check("ws_done", 32'(bus.m_done), 32'h1);
    check("ws_terr", 32'(bus.timeout_err), 32'h0);
    bus.slave_ready = 4'b0000;
    @(negedge clk);
    // asynchronous reset in WAIT clears everything at once and suppresses done
    bus.m_addr0 = 32'h4000_0000;
    bus.m_rw = 2'b01;
    bus.m_req = 2'b01;
    @(negedge clk);
    bus.m_req = 2'b00;
    @(negedge clk);
    check("wr_valid", 32'(bus.bus_valid), 32'h1);
    reset = 1'b1;
    #1;
    idle_outs("async_rst");
    check("async_rst_addr", bus.bus_addr, 32'h0);
    check("async_rst_rw", 32'(bus.bus_rw), 32'h0);
    @(negedge clk);
    check("async_rst_nodone", 32'(bus.m_done), 32'h0);
    reset = 1'b0;
    bus.m_req = 2'b10;
    @(negedge clk);
    check("post_rst_grant1", 32'(bus.m_grant), 32'h2);
    check("post_rst_addr", bus.bus_addr, 32'hC000_0000);
    bus.m_req = 2'b00;
    bus.slave_ready = 4'b1000;
    @(negedge clk);
    check("post_rst_done1", 32'(bus.m_done), 32'h2);
    bus.slave_ready = 4'b0000;
    pulse_reset();
    bus.m_req = 2'b11;
    @(negedge clk);
    check("post_rst_prio0", 32'(bus.m_grant), 32'h1);
    bus.m_req = 2'b00;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
